// File: rtl/icu_sequencer.sv
// icu_sequencer: program sequencer for a 1-bit industrial control unit.
// It fetches 4-bit opcodes and ADDR_W-bit operands from a combinational program
// memory, supports JMP/RTN through a small return stack, and halts on flag_f.

package icu_pkg;
    typedef enum logic [3:0] {
        NOPO = 4'h0, LD   = 4'h1, LDC  = 4'h2, AND_ = 4'h3,
        ANDC = 4'h4, OR_  = 4'h5, ORC  = 4'h6, XNOR_ = 4'h7,
        STO  = 4'h8, STOC = 4'h9, IEN  = 4'hA, OEN  = 4'hB,
        JMP  = 4'hC, RTN  = 4'hD, SKZ  = 4'hE, NOPF = 4'hF
    } instruction_t;
endpackage

module icu_sequencer
    import icu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [ADDR_W+3:0]   mem_data,
    output instruction_t        i,
    output logic [ADDR_W-1:0]   io_addr,
    input  logic                jmp,
    input  logic                rtn,
    input  logic                flag_f,
    input  logic                resume,
    output logic                halted,
    output logic                stack_err
);

    // sp counts occupied entries (0..DEPTH); IDX_W addresses an entry.
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [SP_W-1:0]    sp;
    logic [ADDR_W-1:0]  stack [DEPTH];

    instruction_t       fetch_op;
    logic [ADDR_W-1:0]  fetch_opd;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   top_idx;

    assign mem_addr  = pc;
    assign fetch_op  = instruction_t'(mem_data[ADDR_W+3:ADDR_W]);
    assign fetch_opd = mem_data[ADDR_W-1:0];
    assign push_idx  = IDX_W'(sp);
    assign top_idx   = IDX_W'(sp - SP_W'(1));

    // Sequencer FSM: reset, jump/return with bubble, halt/resume, normal fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pc        <= '0;
            i         <= NOPO;
            io_addr   <= '0;
            sp        <= '0;
            halted    <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (jmp) begin
                        // Jump is always taken; a push into a full stack is dropped.
                        if (sp == SP_FULL) begin
                            stack_err <= 1'b1;
                        end else begin
                            stack[push_idx] <= pc;
                            sp              <= sp + SP_W'(1);
                        end
                        pc      <= io_addr;
                        i       <= NOPO;
                        io_addr <= '0;
                    end else if (rtn) begin
                        if (sp == '0) begin
                            // Underflow: flag it and keep running linearly.
                            stack_err <= 1'b1;
                            i         <= fetch_op;
                            io_addr   <= fetch_opd;
                            pc        <= pc + ADDR_W'(1);
                        end else begin
                            pc      <= stack[top_idx];
                            sp      <= sp - SP_W'(1);
                            i       <= NOPO;
                            io_addr <= '0;
                        end
                    end else if (flag_f) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        i       <= NOPO;
                        io_addr <= '0;
                    end else begin
                        i       <= fetch_op;
                        io_addr <= fetch_opd;
                        pc      <= pc + ADDR_W'(1);
                    end
                end
                HALT: begin
                    // Resume fetches at the held PC on the same edge.
                    if (resume) begin
                        state   <= RUN;
                        halted  <= 1'b0;
                        i       <= fetch_op;
                        io_addr <= fetch_opd;
                        pc      <= pc + ADDR_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_icu_sequencer.sv
// tb_icu_sequencer: directed, table-driven checks of icu_sequencer with a
// combinational program memory modelled as a bench array.

module tb_icu_sequencer;
    import icu_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   mem_addr;
    logic [11:0]  mem_data;
    instruction_t i;
    logic [7:0]   io_addr;
    logic         jmp = 1'b0, rtn = 1'b0, flag_f = 1'b0, resume = 1'b0;
    logic         halted, stack_err;

    logic [11:0]  mem [256];

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic       r, j, t, f, s;
        logic [3:0] ei;
        logic [7:0] eio, ema;
        logic       eh, ee;
    } vec_t;

    vec_t v[$];

    icu_sequencer #(.ADDR_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
        .i(i), .io_addr(io_addr), .jmp(jmp), .rtn(rtn), .flag_f(flag_f),
        .resume(resume), .halted(halted), .stack_err(stack_err)
    );

    assign mem_data = mem[mem_addr];

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic j, logic t, logic f, logic s,
                                logic [3:0] ei, logic [7:0] eio, logic [7:0] ema,
                                logic eh, logic ee);
        vec_t x;
        x.r = r; x.j = j; x.t = t; x.f = f; x.s = s;
        x.ei = ei; x.eio = eio; x.ema = ema; x.eh = eh; x.ee = ee;
        return x;
    endfunction

    // Apply inputs, take one edge, sample 1 ns later.
    task automatic step(input logic r, input logic j, input logic t,
                        input logic f, input logic s);
        rst = r; jmp = j; rtn = t; flag_f = f; resume = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] ei, input logic [7:0] eio,
                       input logic [7:0] ema, input logic eh, input logic ee);
        tests++;
        if (i !== ei || io_addr !== eio || mem_addr !== ema ||
            halted !== eh || stack_err !== ee) begin
            failed++;
            $display("FAIL %s: got i=%h io_addr=%h mem_addr=%h halted=%b err=%b, expected i=%h io_addr=%h mem_addr=%h halted=%b err=%b",
                     nm, i, io_addr, mem_addr, halted, stack_err, ei, eio, ema, eh, ee);
        end
    endtask

    task automatic run_vecs(input string tag);
        for (int k = 0; k < v.size(); k++) begin
            step(v[k].r, v[k].j, v[k].t, v[k].f, v[k].s);
            chk($sformatf("%s[%0d]", tag, k), v[k].ei, v[k].eio, v[k].ema, v[k].eh, v[k].ee);
        end
        v.delete();
    endtask

    initial begin
        logic [7:0] tgt [6];
        logic [7:0] ret [4];
        logic [7:0] a;

        for (int k = 0; k < 256; k++) begin
            a = 8'(k);
            mem[k] = {a[3:0], ~a};
        end
        mem[0] = {LD,   8'h05};
        mem[1] = {OR_,  8'h06};
        mem[2] = {STO,  8'h07};
        mem[3] = {NOPO, 8'h00};

        // Linear program
        v.push_back(mk(1,0,0,0,0, NOPO, 8'h00, 8'h00, 0, 0));
        v.push_back(mk(0,0,0,0,0, LD,   8'h05, 8'h01, 0, 0));
        v.push_back(mk(0,0,0,0,0, OR_,  8'h06, 8'h02, 0, 0));
        v.push_back(mk(0,0,0,0,0, STO,  8'h07, 8'h03, 0, 0));
        v.push_back(mk(0,0,0,0,0, NOPO, 8'h00, 8'h04, 0, 0));
        run_vecs("linear");

        // Jump/return, underflow, priorities, stray resume
        mem[2]    = {JMP, 8'h20};
        mem[8'h22] = {RTN, 8'h00};
        v.push_back(mk(1,0,0,0,0, NOPO, 8'h00, 8'h00, 0, 0));
        v.push_back(mk(0,0,0,0,0, LD,   8'h05, 8'h01, 0, 0));
        v.push_back(mk(0,0,0,0,0, OR_,  8'h06, 8'h02, 0, 0));
        v.push_back(mk(0,0,0,0,0, JMP,  8'h20, 8'h03, 0, 0));
        v.push_back(mk(0,1,0,0,0, NOPO, 8'h00, 8'h20, 0, 0));
        v.push_back(mk(0,0,0,0,0, NOPO, 8'hDF, 8'h21, 0, 0));
        v.push_back(mk(0,0,0,0,0, LD,   8'hDE, 8'h22, 0, 0));
        v.push_back(mk(0,0,0,0,0, RTN,  8'h00, 8'h23, 0, 0));
        v.push_back(mk(0,0,1,0,0, NOPO, 8'h00, 8'h03, 0, 0));
        v.push_back(mk(0,0,0,0,0, NOPO, 8'h00, 8'h04, 0, 0));
        v.push_back(mk(0,0,0,0,0, ANDC, 8'hFB, 8'h05, 0, 0));
        v.push_back(mk(0,0,1,0,0, OR_,  8'hFA, 8'h06, 0, 1));
        v.push_back(mk(0,1,1,1,0, NOPO, 8'h00, 8'hFA, 0, 1));
        v.push_back(mk(0,0,0,0,0, IEN,  8'h05, 8'hFB, 0, 1));
        v.push_back(mk(0,0,1,1,0, NOPO, 8'h00, 8'h06, 0, 1));
        v.push_back(mk(0,0,0,0,1, ORC,  8'hF9, 8'h07, 0, 1));
        run_vecs("jmprtn");

        // Halt at PC 09 for 10 cycles, ignoring jmp/rtn/flag_f, then resume
        step(1,0,0,0,0);
        chk("halt_reset", NOPO, 8'h00, 8'h00, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            step(0,0,0,0,0);
            chk($sformatf("halt_pre[%0d]", k), mem[k-1][11:8], mem[k-1][7:0], 8'(k), 0, 0);
        end
        step(0,0,0,1,0);
        chk("halt_enter", NOPO, 8'h00, 8'h09, 1, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, k[0], k[1], k[2], 0);
            chk($sformatf("halt_hold[%0d]", k), NOPO, 8'h00, 8'h09, 1, 0);
        end
        step(0,0,0,0,1);
        chk("halt_resume", mem[9][11:8], mem[9][7:0], 8'h0A, 0, 0);

        // Reset during halt with two stack entries
        step(1,0,0,0,0);
        step(0,0,0,0,0);
        step(0,0,0,0,0);
        step(0,0,0,0,0);
        chk("rsth_jmpop", JMP, 8'h20, 8'h03, 0, 0);
        step(0,1,0,0,0);
        chk("rsth_jmp1", NOPO, 8'h00, 8'h20, 0, 0);
        step(0,0,0,0,0);
        step(0,1,0,0,0);
        chk("rsth_jmp2", NOPO, 8'h00, 8'hDF, 0, 0);
        step(0,0,0,0,0);
        step(0,0,0,1,0);
        chk("rsth_halt", NOPO, 8'h00, 8'hE0, 1, 0);
        step(1,0,0,0,1);
        chk("rsth_reset", NOPO, 8'h00, 8'h00, 0, 0);
        step(0,0,0,0,0);
        chk("rsth_fetch0", LD, 8'h05, 8'h01, 0, 0);
        step(0,0,1,0,0);
        chk("rsth_stack_empty", OR_, 8'h06, 8'h02, 0, 1);

        // Five nested jumps into a four-deep stack, then unwind
        tgt[0] = 8'h40; tgt[1] = 8'h50; tgt[2] = 8'h60; tgt[3] = 8'h70; tgt[4] = 8'h80;
        mem[0] = {JMP, tgt[0]};
        for (int k = 0; k < 4; k++) mem[tgt[k]] = {JMP, tgt[k+1]};
        ret[0] = 8'h61; ret[1] = 8'h51; ret[2] = 8'h41; ret[3] = 8'h01;
        step(1,0,0,0,0);
        step(0,0,0,0,0);
        chk("nest_start", JMP, 8'h40, 8'h01, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0,1,0,0,0);
            chk($sformatf("nest_jmp[%0d]", k), NOPO, 8'h00, tgt[k], 0, (k == 4));
            step(0,0,0,0,0);
            chk($sformatf("nest_tgt[%0d]", k), mem[tgt[k]][11:8], mem[tgt[k]][7:0],
                tgt[k] + 8'h01, 0, (k == 4));
        end
        for (int k = 0; k < 4; k++) begin
            step(0,0,1,0,0);
            chk($sformatf("nest_rtn[%0d]", k), NOPO, 8'h00, ret[k], 0, 1);
            step(0,0,0,0,0);
            chk($sformatf("nest_ret[%0d]", k), mem[ret[k]][11:8], mem[ret[k]][7:0],
                ret[k] + 8'h01, 0, 1);
        end
        step(0,0,1,0,0);
        chk("nest_underflow", JMP, 8'h20, 8'h03, 0, 1);

        // PC wraps from FF to 00
        mem[3] = {JMP, 8'hFF};
        step(0,0,0,0,0);
        chk("wrap_op", JMP, 8'hFF, 8'h04, 0, 1);
        step(0,1,0,0,0);
        chk("wrap_jmp", NOPO, 8'h00, 8'hFF, 0, 1);
        step(0,0,0,0,0);
        chk("wrap_fetch", NOPF, 8'h00, 8'h00, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
